lsu_handshake: RTL and testbench
================================

LSU_HANDSHAKE -- requirements
Module: lsu_handshake

Interface
Parameters:
REQ-001 SHALL provide parameter ADDR_W, default 32, address width in bits.
REQ-002 SHALL provide parameter DATA_W, default 32, bus data width; legal values are 32 and 64 only.
REQ-003 SHALL provide parameter TIMEOUT, default 255, bus wait limit in cycles; 0 disables the timeout.

Ports (name, direction, width, meaning):
REQ-004 SHALL provide the following ports:
- clk  in  1  clock; rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  rt value: store data, and merge source for LWL/LWR.
- req_type  in  2  `MEM_NOOP / `MEM_LOAD / `MEM_STOR.
- req_size  in  3  `SZ_BYTE / `SZ_HALF / `SZ_FULL / SZ_LEFT / SZ_RIGH.
- req_signed  in  1  1 = sign-extend loads, 0 = zero-extend.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed.
- resp_data  out  32  load result; request address for non-loads.
- resp_addr_err  out  1  alignment or illegal-size error.
- resp_bus_err  out  1  timeout error.
- bus_req, bus_wr  out  1  bus request; write qualifier.
- bus_be  out  DATA_W/8  byte enables; all zero for reads.
- bus_addr  out  ADDR_W  word-aligned bus address (low log2(DATA_W/8) bits zero).
- bus_wdata  out  DATA_W  store data.
- bus_addr_ok, bus_data_ok  in  1  address accepted; data phase complete.
- bus_rdata  in  DATA_W  read data, valid with bus_data_ok.

Function
REQ-005 SHALL implement an FSM with states IDLE, ADDR, DATA, RESP; req_ready SHALL equal (state==IDLE).
REQ-006 On accept of a request with req_type=`MEM_NOOP, SHALL go IDLE->RESP with resp_data=req_addr and no bus activity.
REQ-007 On accept, SHALL compute the alignment error: `SZ_HALF with addr[0]=1, or `SZ_FULL with addr[1:0]!=0; on error SHALL go IDLE->RESP with resp_addr_err=1 and no bus activity.
REQ-008 On accept of a legal load or store, SHALL go IDLE->ADDR and hold bus_req=1 with bus_addr/bus_wr/bus_be/bus_wdata stable until bus_addr_ok.
REQ-009 In ADDR, bus_addr_ok SHALL move the FSM to DATA and drop bus_req the following cycle; bus_addr_ok together with bus_data_ok in the same cycle SHALL move the FSM directly to RESP.
REQ-010 In DATA, bus_data_ok SHALL move the FSM to RESP; bus_data_ok while IDLE or RESP SHALL be ignored.
REQ-011 Minimum latency: accept in cycle 0, bus_req in cycle 1, resp_valid in the cycle after the data_ok cycle.
REQ-012 In RESP, resp_valid=1 and resp_* SHALL be held stable until resp_ready; resp_ready SHALL return the FSM to IDLE (no same-cycle re-accept).
REQ-013 Lane selection:
- lane = addr[2] when DATA_W=64, else 0.
- bus_be SHALL be the 4-bit word enable shifted into that lane.
- bus_wdata SHALL replicate the 32-bit word in every lane.
- load extraction SHALL read from the selected lane.
REQ-014 Store enables and data within the word:
- byte k: be=1<<k, data = rt[7:0] replicated x4.
- half: be=0011 or 1100 per addr[1], data = rt[15:0] replicated x2.
- full: be=1111, data = rt.
REQ-015 Loads SHALL extract the addressed byte or half and extend it per req_signed; full loads SHALL return the word unchanged.
REQ-016 A 32-bit cycle counter SHALL clear on accept and increment in ADDR and DATA; when TIMEOUT!=0 and count==TIMEOUT, the FSM SHALL go to RESP with resp_bus_err=1 and drop bus_req.

Reset
REQ-017 SHALL, on rst=1 at any time (including mid-transaction), force IDLE and clear the counter.
REQ-018 Reset values SHALL be: resp_valid=0, bus_req=0, bus_wr=0, bus_be=0, resp_data=0, resp_addr_err=0, resp_bus_err=0.
REQ-019 A transaction in progress at reset SHALL be abandoned and SHALL NOT produce a response.

Configuration
REQ-020 With LSU_UNALIGNED_EN defined, SZ_LEFT and SZ_RIGH SHALL be supported, with k=addr[1:0]:
- SWL: be=bits 0..k, wdata = rt>>8*(3-k).
- SWR: be=bits k..3, wdata = rt<<8k.
- LWL: result = {mem[8k+7:0], rt[23-8k:0]}.
- LWR: result = {rt[31:32-8k], mem[31:8k]}.
REQ-021 Without LSU_UNALIGNED_EN, SZ_LEFT and SZ_RIGH SHALL be rejected as in REQ-007 (resp_addr_err=1, no bus activity).

Verification
REQ-022 LB with signed=1, addr=0x1003, rdata=0x80112233 -> bus_be=0000, resp_data=0xFFFFFF80.
REQ-023 SH, addr=0x2002, rt=0x0000BEEF -> bus_be=1100, bus_wdata=0xBEEFBEEF; with DATA_W=64 and addr=0x2006 -> bus_be=0xC0.
REQ-024 LW at addr=0x3001 -> resp_addr_err=1 one cycle after accept, bus_req never asserted.
REQ-025 bus_addr_ok never asserted, TIMEOUT=4 -> resp_bus_err=1; a later bus_data_ok is ignored.
REQ-026 With LSU_UNALIGNED_EN: LWL addr=0x11, rt=0xAABBCCDD, rdata=0x44332211 -> resp_data=0x2211CCDD; rst asserted while in DATA -> IDLE, no response.

Source files
------------

// File: rtl/lsu_handshake.sv
// ---------------------------------------------------------------------------
// lsu_handshake
//
// Load/store unit front end. Takes one memory request at a time, checks its
// alignment, drives a split address/data bus handshake, and hands back one
// response per accepted request. Loads are extracted from the addressed
// byte lane and sign- or zero-extended. Stores are replicated across the
// bus lanes and qualified with byte enables.
//
// Optional feature macro: LSU_UNALIGNED_EN
//   When defined, SZ_LEFT / SZ_RIGH (SWL/SWR/LWL/LWR style partial-word
//   accesses) are supported. When undefined they are rejected with
//   resp_addr_err, exactly like a misaligned access.
//
// Parameters
//   ADDR_W   address width in bits (at least 3)
//   DATA_W   bus width, 32 or 64 only
//   TIMEOUT  bus wait limit in cycles, 0 disables the timeout
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   req_valid / req_ready    request handshake; req_ready is high in IDLE
//   req_addr                 byte address
//   req_wdata                rt value: store data and LWL/LWR merge source
//   req_type                 0 NOOP, 1 LOAD, 2 STORE (3 behaves as NOOP)
//   req_size                 0 BYTE, 1 HALF, 2 FULL, 3 LEFT, 4 RIGH
//   req_signed               1 sign-extends byte/half loads
//   resp_valid / resp_ready  response handshake
//   resp_data                load result, otherwise the request address
//   resp_addr_err            misaligned or unsupported size
//   resp_bus_err             bus timeout
//   bus_req, bus_wr          bus request and write qualifier
//   bus_be                   byte enables, zero for reads
//   bus_addr                 lane-aligned bus address
//   bus_wdata                store data replicated in every 32-bit lane
//   bus_addr_ok              address phase accepted
//   bus_data_ok              data phase complete, bus_rdata valid
//   bus_rdata                read data
// ---------------------------------------------------------------------------
module lsu_handshake #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [31:0]         req_wdata,
  input  logic [1:0]          req_type,
  input  logic [2:0]          req_size,
  input  logic                req_signed,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [31:0]         resp_data,
  output logic                resp_addr_err,
  output logic                resp_bus_err,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam logic [1:0] MEM_NOOP = 2'd0;
  localparam logic [1:0] MEM_LOAD = 2'd1;
  localparam logic [1:0] MEM_STOR = 2'd2;

  localparam logic [2:0] SZ_BYTE = 3'd0;
  localparam logic [2:0] SZ_HALF = 3'd1;
  localparam logic [2:0] SZ_FULL = 3'd2;
  localparam logic [2:0] SZ_LEFT = 3'd3;
  localparam logic [2:0] SZ_RIGH = 3'd4;

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [31:0]       r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_size;
  logic              r_signed;
  logic              r_isLoad;
  logic              r_isStore;
  logic [3:0]        r_be4;
  logic [31:0]       r_word;
  logic [31:0]       r_respData;
  logic              r_addrErr;
  logic              r_busErr;
`ifdef LSU_UNALIGNED_EN
  logic [31:0]       r_rt;
`endif

  logic [1:0]        w_k;
  logic              w_isMem;
  logic              w_alignErr;
  logic [3:0]        w_be4;
  logic [31:0]       w_word;
  logic              w_accept;
  logic              w_timeout;
  logic              w_dataDone;
  logic              w_timeoutHit;
  logic              w_lane;
  logic [31:0]       w_rdWord;
  logic [BE_W-1:0]   w_beLane;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_loadResult;

  assign w_k     = req_addr[1:0];
  assign w_isMem = (req_type == MEM_LOAD) || (req_type == MEM_STOR);

  // Decode the incoming request: byte enables within the 32-bit word, the
  // store data arranged within that word, and whether the size/alignment
  // combination is illegal. Reads never assert byte enables, and requests
  // that do not touch memory can never raise an alignment error.
  always_comb begin
    w_alignErr = 1'b0;
    w_be4      = 4'b0000;
    w_word     = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        w_be4  = 4'b0001 << w_k;
        w_word = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_be4      = req_addr[1] ? 4'b1100 : 4'b0011;
        w_word     = {2{req_wdata[15:0]}};
        w_alignErr = req_addr[0];
      end
      SZ_FULL: begin
        w_be4      = 4'b1111;
        w_alignErr = (w_k != 2'b00);
      end
`ifdef LSU_UNALIGNED_EN
      SZ_LEFT: begin
        // (2 << k) - 1 gives a mask of bits 0..k; k=3 wraps to 4'b1111
        w_be4  = (4'b0010 << w_k) - 4'd1;
        w_word = req_wdata >> {(2'd3 - w_k), 3'b000};
      end
      SZ_RIGH: begin
        w_be4  = 4'b1111 << w_k;
        w_word = req_wdata << {w_k, 3'b000};
      end
`endif
      default: begin
        w_alignErr = 1'b1;
      end
    endcase
    if (req_type != MEM_STOR) begin
      w_be4 = 4'b0000;
    end
    if (!w_isMem) begin
      w_alignErr = 1'b0;
    end
  end

  // Lane handling differs between the 32-bit and 64-bit bus: on a 64-bit
  // bus address bit 2 picks the upper or lower 32-bit half.
  generate
    if (DATA_W == 64) begin : g_lane64
      assign w_lane   = r_addr[2];
      assign w_rdWord = w_lane ? bus_rdata[63:32] : bus_rdata[31:0];
    end else begin : g_lane32
      assign w_lane   = 1'b0;
      assign w_rdWord = bus_rdata[31:0];
    end
  endgenerate

  assign w_beLane = BE_W'(r_be4) << {w_lane, 2'b00};

  // Shape the selected read word into the load result. Byte and half loads
  // are extended per the captured signed flag; full loads pass unchanged.
  // LWL/LWR merge the loaded bytes with the captured rt value.
  always_comb begin
    w_byte       = w_rdWord[{r_addr[1:0], 3'b000} +: 8];
    w_half       = r_addr[1] ? w_rdWord[31:16] : w_rdWord[15:0];
    w_loadResult = w_rdWord;
    case (r_size)
      SZ_BYTE: w_loadResult = {{24{r_signed & w_byte[7]}}, w_byte};
      SZ_HALF: w_loadResult = {{16{r_signed & w_half[15]}}, w_half};
`ifdef LSU_UNALIGNED_EN
      SZ_LEFT: w_loadResult = (w_rdWord << {(2'd3 - r_addr[1:0]), 3'b000})
                            | (r_rt & (32'h00FF_FFFF >> {r_addr[1:0], 3'b000}));
      SZ_RIGH: w_loadResult = (w_rdWord >> {r_addr[1:0], 3'b000})
                            | (r_rt & ~(32'hFFFF_FFFF >> {r_addr[1:0], 3'b000}));
`endif
      default: w_loadResult = w_rdWord;
    endcase
  end

  // Timeout fires when the bus wait counter reaches the limit; it takes
  // priority over a handshake landing in the same cycle.
  assign w_accept     = (r_state == IDLE) && req_valid;
  assign w_timeout    = (TIMEOUT != 0) && (r_count == 32'(TIMEOUT));
  assign w_timeoutHit = ((r_state == ADDR) || (r_state == DATA)) && w_timeout;
  assign w_dataDone   = !w_timeout &&
                        (((r_state == ADDR) && bus_addr_ok && bus_data_ok) ||
                         ((r_state == DATA) && bus_data_ok));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Non-memory and erroring requests skip the bus and go
  // straight to RESP. bus_data_ok outside ADDR/DATA is never looked at.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_nextState = (w_isMem && !w_alignErr) ? ADDR : RESP;
        end
      end
      ADDR: begin
        if (w_timeout) begin
          w_nextState = RESP;
        end else if (bus_addr_ok && bus_data_ok) begin
          w_nextState = RESP;
        end else if (bus_addr_ok) begin
          w_nextState = DATA;
        end
      end
      DATA: begin
        if (w_timeout || bus_data_ok) begin
          w_nextState = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Output decode. The bus is only driven while the address phase is open,
  // which keeps enables and write qualifier low everywhere else.
  always_comb begin
    req_ready  = (r_state == IDLE);
    resp_valid = (r_state == RESP);
    bus_req    = (r_state == ADDR);
    bus_wr     = (r_state == ADDR) && r_isStore;
    bus_be     = (r_state == ADDR) ? w_beLane : '0;
  end

  assign bus_addr      = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign bus_wdata     = {(DATA_W/32){r_word}};
  assign resp_data     = r_respData;
  assign resp_addr_err = r_addrErr;
  assign resp_bus_err  = r_busErr;

  // Bus wait counter: restarts on every accepted request and runs for as
  // long as the transaction sits in either bus phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 32'd0;
    end else if (w_accept) begin
      r_count <= 32'd0;
    end else if ((r_state == ADDR) || (r_state == DATA)) begin
      r_count <= r_count + 32'd1;
    end
  end

  // Request capture and response building. Everything the bus and the
  // response need is latched at accept so the requester may change its
  // inputs immediately. The response defaults to the request address and
  // is overwritten by the load result when the data phase completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_size     <= 3'd0;
      r_signed   <= 1'b0;
      r_isLoad   <= 1'b0;
      r_isStore  <= 1'b0;
      r_be4      <= 4'b0000;
      r_word     <= 32'd0;
      r_respData <= 32'd0;
      r_addrErr  <= 1'b0;
      r_busErr   <= 1'b0;
`ifdef LSU_UNALIGNED_EN
      r_rt       <= 32'd0;
`endif
    end else if (w_accept) begin
      r_addr     <= req_addr;
      r_size     <= req_size;
      r_signed   <= req_signed;
      r_isLoad   <= (req_type == MEM_LOAD);
      r_isStore  <= (req_type == MEM_STOR);
      r_be4      <= w_be4;
      r_word     <= w_word;
      r_respData <= 32'(req_addr);
      r_addrErr  <= w_alignErr;
      r_busErr   <= 1'b0;
`ifdef LSU_UNALIGNED_EN
      r_rt       <= req_wdata;
`endif
    end else if (w_timeoutHit) begin
      r_busErr <= 1'b1;
    end else if (w_dataDone && r_isLoad) begin
      r_respData <= w_loadResult;
    end
  end

endmodule

// File: tb/tb_lsu_handshake.sv
// ---------------------------------------------------------------------------
// tb_lsu_handshake
//
// Runs a 32-bit and a 64-bit lsu_handshake side by side on the same request
// and bus control inputs (each with its own read data) and compares both
// against a behavioural model built from byte-level access rules and a
// cycle timeline of the bus handshake.
// ---------------------------------------------------------------------------
module tb_lsu_handshake;

  localparam int TO = 4;
`ifdef LSU_UNALIGNED_EN
  localparam bit UNAL = 1'b1;
`else
  localparam bit UNAL = 1'b0;
`endif

  localparam logic [1:0] T_NOOP = 2'd0;
  localparam logic [1:0] T_LOAD = 2'd1;
  localparam logic [1:0] T_STOR = 2'd2;
  localparam logic [2:0] S_BYTE = 3'd0;
  localparam logic [2:0] S_HALF = 3'd1;
  localparam logic [2:0] S_FULL = 3'd2;
  localparam logic [2:0] S_LEFT = 3'd3;
  localparam logic [2:0] S_RIGH = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_type;
  logic [2:0]  req_size;
  logic        req_signed;
  logic        resp_ready;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] rdata32;
  logic [63:0] rdata64;

  logic        a_req_ready, a_resp_valid, a_resp_addr_err, a_resp_bus_err;
  logic        a_bus_req, a_bus_wr;
  logic [31:0] a_resp_data, a_bus_addr, a_bus_wdata;
  logic [3:0]  a_bus_be;

  logic        b_req_ready, b_resp_valid, b_resp_addr_err, b_resp_bus_err;
  logic        b_bus_req, b_bus_wr;
  logic [31:0] b_resp_data, b_bus_addr;
  logic [63:0] b_bus_wdata;
  logic [7:0]  b_bus_be;

  int checks   = 0;
  int failures = 0;
  int txnNum   = 0;

  logic [31:0] lastResp32, lastResp64, lastWdata32;
  logic [3:0]  lastBe32;
  logic [7:0]  lastBe64;
  logic        lastAddrErr, lastBusErr, sawReq;
  int          firstRespCycle;

  always #5 clk = ~clk;

  lsu_handshake #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(a_req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_type(req_type), .req_size(req_size),
    .req_signed(req_signed),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready), .resp_data(a_resp_data),
    .resp_addr_err(a_resp_addr_err), .resp_bus_err(a_resp_bus_err),
    .bus_req(a_bus_req), .bus_wr(a_bus_wr), .bus_be(a_bus_be),
    .bus_addr(a_bus_addr), .bus_wdata(a_bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(rdata32)
  );

  lsu_handshake #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(TO)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(b_req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_type(req_type), .req_size(req_size),
    .req_signed(req_signed),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready), .resp_data(b_resp_data),
    .resp_addr_err(b_resp_addr_err), .resp_bus_err(b_resp_bus_err),
    .bus_req(b_bus_req), .bus_wr(b_bus_wr), .bus_be(b_bus_be),
    .bus_addr(b_bus_addr), .bus_wdata(b_bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(rdata64)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s (txn %0d): got 0x%0h, expected 0x%0h",
               tag, txnNum, actual, expected);
    end
  endtask

  // Is the request rejected without touching the bus?
  function automatic logic modelErr(input logic [1:0] t, input logic [2:0] s,
                                    input logic [31:0] a);
    if (t != T_LOAD && t != T_STOR) return 1'b0;
    case (s)
      S_BYTE:         return 1'b0;
      S_HALF:         return a[0];
      S_FULL:         return a[1:0] != 2'b00;
      S_LEFT, S_RIGH: return !UNAL;
      default:        return 1'b1;
    endcase
  endfunction

  // Which bytes of the 32-bit word a store writes.
  function automatic logic [3:0] modelBe4(input logic [1:0] t, input logic [2:0] s,
                                          input logic [31:0] a);
    logic [3:0] be;
    int k;
    k  = int'(a[1:0]);
    be = 4'b0000;
    if (t == T_STOR) begin
      for (int i = 0; i < 4; i++) begin
        case (s)
          S_BYTE:  be[i] = (i == k);
          S_HALF:  be[i] = ((i / 2) == int'(a[1]));
          S_FULL:  be[i] = 1'b1;
          S_LEFT:  be[i] = (i <= k);
          S_RIGH:  be[i] = (i >= k);
          default: be[i] = 1'b0;
        endcase
      end
    end
    return be;
  endfunction

  // Store data as it appears within the 32-bit word.
  function automatic logic [31:0] modelWord(input logic [2:0] s, input logic [31:0] a,
                                            input logic [31:0] rt);
    logic [31:0] w;
    int k;
    k = int'(a[1:0]);
    w = 32'd0;
    for (int i = 0; i < 4; i++) begin
      case (s)
        S_BYTE: w[8*i +: 8] = rt[7:0];
        S_HALF: w[8*i +: 8] = rt[8*(i%2) +: 8];
        S_LEFT: if (i <= k) w[8*i +: 8] = rt[8*(i+3-k) +: 8];
        S_RIGH: if (i >= k) w[8*i +: 8] = rt[8*(i-k) +: 8];
        default: w[8*i +: 8] = rt[8*i +: 8];
      endcase
    end
    return w;
  endfunction

  // Load result from the selected 32-bit memory word.
  function automatic logic [31:0] modelLoad(input logic [2:0] s, input logic sg,
                                            input logic [31:0] a, input logic [31:0] mem,
                                            input logic [31:0] rt);
    logic [31:0] r;
    logic [7:0]  b;
    logic [15:0] h;
    int k;
    k = int'(a[1:0]);
    r = mem;
    case (s)
      S_BYTE: begin
        b = mem[8*k +: 8];
        r = {24'd0, b};
        if (sg && b[7]) r = r | 32'hFFFF_FF00;
      end
      S_HALF: begin
        h = a[1] ? mem[31:16] : mem[15:0];
        r = {16'd0, h};
        if (sg && h[15]) r = r | 32'hFFFF_0000;
      end
      S_LEFT: begin
        for (int i = 0; i < 4; i++) begin
          if (i >= 3 - k) r[8*i +: 8] = mem[8*(i-3+k) +: 8];
          else            r[8*i +: 8] = rt[8*i +: 8];
        end
      end
      S_RIGH: begin
        for (int i = 0; i < 4; i++) begin
          if (i < 4 - k) r[8*i +: 8] = mem[8*(i+k) +: 8];
          else           r[8*i +: 8] = rt[8*i +: 8];
        end
      end
      default: r = mem;
    endcase
    return r;
  endfunction

  // One complete transaction. The bus answers addr_ok A cycles after the
  // request rises and data_ok D cycles after that; the response is held R
  // cycles before being taken. Cycle 0 is the accept cycle.
  task automatic applyStimulus(input logic [1:0] t, input logic [2:0] s, input logic sg,
                               input logic [31:0] a, input logic [31:0] rt,
                               input int A, input int D, input int R, input logic spur,
                               input logic [31:0] rd32In, input logic [63:0] rd64In);
    logic        err, bus, busErr;
    int          addrCycle, tc, toCycle, respCycle, reqEnd, lastCycle;
    logic [31:0] exp32, exp64, word64, wword;
    logic [3:0]  be4;
    logic [7:0]  be64;

    txnNum++;
    err       = modelErr(t, s, a);
    bus       = (t == T_LOAD || t == T_STOR) && !err;
    addrCycle = 1 + A;
    tc        = addrCycle + D;
    toCycle   = TO + 1;
    busErr    = 1'b0;
    respCycle = 1;
    reqEnd    = 0;
    if (bus) begin
      if (tc < toCycle) begin
        respCycle = tc + 1;
        reqEnd    = addrCycle;
      end else begin
        busErr    = 1'b1;
        respCycle = toCycle + 1;
        reqEnd    = (addrCycle < toCycle) ? addrCycle : toCycle;
      end
    end
    lastCycle = respCycle + R;
    word64    = a[2] ? rd64In[63:32] : rd64In[31:0];
    exp32     = a;
    exp64     = a;
    if (bus && !busErr && t == T_LOAD) begin
      exp32 = modelLoad(s, sg, a, rd32In, rt);
      exp64 = modelLoad(s, sg, a, word64, rt);
    end
    be4   = modelBe4(t, s, a);
    be64  = a[2] ? {be4, 4'b0000} : {4'b0000, be4};
    wword = modelWord(s, a, rt);

    req_valid   = 1'b1;
    req_type    = t;
    req_size    = s;
    req_signed  = sg;
    req_addr    = a;
    req_wdata   = rt;
    bus_addr_ok = 1'b0;
    bus_data_ok = spur;
    resp_ready  = 1'b0;
    rdata32     = $urandom;
    rdata64     = {$urandom, $urandom};
    @(negedge clk);
    checkOutput("idleReady32", a_req_ready, 1);
    checkOutput("idleReady64", b_req_ready, 1);
    checkOutput("idleRespValid", a_resp_valid, 0);
    @(posedge clk);
    #1;

    sawReq = 1'b0;
    firstRespCycle = -1;
    for (int c = 1; c <= lastCycle; c++) begin
      req_valid   = 1'b0;
      req_addr    = $urandom;
      req_wdata   = $urandom;
      req_type    = 2'($urandom_range(0, 3));
      req_size    = 3'($urandom_range(0, 7));
      req_signed  = 1'($urandom_range(0, 1));
      bus_addr_ok = bus && (c == addrCycle) && (addrCycle <= toCycle);
      bus_data_ok = (bus && (c == tc) && (addrCycle <= toCycle)) ||
                    (spur && (c >= respCycle) && ($urandom_range(0, 1) == 1));
      resp_ready  = (c == lastCycle) || ((c < respCycle) && ($urandom_range(0, 1) == 1));
      rdata32     = (c == tc) ? rd32In : $urandom;
      rdata64     = (c == tc) ? rd64In : {$urandom, $urandom};
      @(negedge clk);
      sawReq = sawReq | a_bus_req | b_bus_req;
      if (a_resp_valid && firstRespCycle < 0) firstRespCycle = c;
      checkOutput("busyReady", a_req_ready | b_req_ready, 0);
      checkOutput("busReq32", a_bus_req, bus && (c <= reqEnd));
      checkOutput("busReq64", b_bus_req, bus && (c <= reqEnd));
      if (bus && c <= reqEnd) begin
        checkOutput("busAddr32", a_bus_addr, a & 32'hFFFF_FFFC);
        checkOutput("busAddr64", b_bus_addr, a & 32'hFFFF_FFF8);
        checkOutput("busWr32", a_bus_wr, t == T_STOR);
        checkOutput("busWr64", b_bus_wr, t == T_STOR);
        checkOutput("busBe32", a_bus_be, be4);
        checkOutput("busBe64", b_bus_be, be64);
        if (t == T_STOR) begin
          checkOutput("busWdata32", a_bus_wdata, wword);
          checkOutput("busWdata64", b_bus_wdata, {wword, wword});
        end
        if (c == 1) begin
          lastBe32    = a_bus_be;
          lastBe64    = b_bus_be;
          lastWdata32 = a_bus_wdata;
        end
      end
      checkOutput("respValid32", a_resp_valid, c >= respCycle);
      checkOutput("respValid64", b_resp_valid, c >= respCycle);
      if (c >= respCycle) begin
        checkOutput("respData32", a_resp_data, exp32);
        checkOutput("respData64", b_resp_data, exp64);
        checkOutput("addrErr", {b_resp_addr_err, a_resp_addr_err}, {err, err});
        checkOutput("busErr", {b_resp_bus_err, a_resp_bus_err}, {busErr, busErr});
        if (c == respCycle) begin
          lastResp32  = a_resp_data;
          lastResp64  = b_resp_data;
          lastAddrErr = a_resp_addr_err;
          lastBusErr  = a_resp_bus_err;
        end
      end
      @(posedge clk);
      #1;
    end
    resp_ready  = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
  endtask

  // Reset values on every output that has one.
  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_respValid"}, {b_resp_valid, a_resp_valid}, 0);
    checkOutput({tag, "_busReq"}, {b_bus_req, a_bus_req}, 0);
    checkOutput({tag, "_busWr"}, {b_bus_wr, a_bus_wr}, 0);
    checkOutput({tag, "_busBe"}, {b_bus_be, a_bus_be}, 0);
    checkOutput({tag, "_respData"}, {b_resp_data, a_resp_data}, 0);
    checkOutput({tag, "_errs"}, {b_resp_addr_err, b_resp_bus_err,
                                 a_resp_addr_err, a_resp_bus_err}, 0);
    checkOutput({tag, "_ready"}, {b_req_ready, a_req_ready}, 2'b11);
  endtask

  initial begin
    logic [1:0]  t;
    logic [2:0]  s;

    rst         = 1'b1;
    req_valid   = 1'b0;
    req_addr    = 32'd0;
    req_wdata   = 32'd0;
    req_type    = 2'd0;
    req_size    = 3'd0;
    req_signed  = 1'b0;
    resp_ready  = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    rdata32     = 32'd0;
    rdata64     = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // LB signed from the top byte of the word
    applyStimulus(T_LOAD, S_BYTE, 1'b1, 32'h0000_1003, 32'h1234_5678, 0, 0, 0, 1'b0,
                  32'h8011_2233, {32'h5555_AAAA, 32'h8011_2233});
    checkOutput("lbSigned32", lastResp32, 32'hFFFF_FF80);
    checkOutput("lbSigned64", lastResp64, 32'hFFFF_FF80);

    // SH to the upper half, then the same in the upper 64-bit lane
    applyStimulus(T_STOR, S_HALF, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 1, 1, 1, 1'b0,
                  32'd0, 64'd0);
    checkOutput("shBe32", lastBe32, 4'b1100);
    checkOutput("shWdata32", lastWdata32, 32'hBEEF_BEEF);
    applyStimulus(T_STOR, S_HALF, 1'b0, 32'h0000_2006, 32'h0000_BEEF, 0, 2, 0, 1'b0,
                  32'd0, 64'd0);
    checkOutput("shBe64", lastBe64, 8'hC0);

    // Misaligned LW: immediate error response, no bus request
    applyStimulus(T_LOAD, S_FULL, 1'b0, 32'h0000_3001, 32'd0, 0, 0, 2, 1'b1,
                  32'd0, 64'd0);
    checkOutput("lwMisalignErr", lastAddrErr, 1);
    checkOutput("lwMisalignCycle", firstRespCycle, 1);
    checkOutput("lwMisalignNoReq", sawReq, 0);

    // No-op returns the address without bus activity
    applyStimulus(T_NOOP, S_FULL, 1'b0, 32'hDEAD_BEE1, 32'd0, 0, 0, 0, 1'b0,
                  32'd0, 64'd0);
    checkOutput("noopData", lastResp32, 32'hDEAD_BEE1);
    checkOutput("noopNoReq", sawReq, 0);

    // Address phase never accepted: timeout, late data_ok ignored
    applyStimulus(T_LOAD, S_FULL, 1'b0, 32'h0000_4000, 32'd0, 10, 0, 3, 1'b1,
                  32'h1111_1111, 64'd0);
    checkOutput("toAddrBusErr", lastBusErr, 1);
    checkOutput("toAddrCycle", firstRespCycle, TO + 2);
    // Timeout while waiting for data
    applyStimulus(T_STOR, S_FULL, 1'b0, 32'h0000_4004, 32'hCAFE_F00D, 1, 10, 1, 1'b1,
                  32'd0, 64'd0);
    checkOutput("toDataBusErr", lastBusErr, 1);
    // Either side of the timeout boundary
    applyStimulus(T_LOAD, S_FULL, 1'b0, 32'h0000_4008, 32'd0, 2, 1, 0, 1'b0,
                  32'h7777_1234, {32'h7777_1234, 32'h0});
    checkOutput("justInTime", lastBusErr, 0);
    checkOutput("justInTimeData", lastResp32, 32'h7777_1234);
    applyStimulus(T_LOAD, S_FULL, 1'b0, 32'h0000_400C, 32'd0, 2, 2, 0, 1'b0,
                  32'h7777_1234, 64'd0);
    checkOutput("justLate", lastBusErr, 1);

`ifdef LSU_UNALIGNED_EN
    applyStimulus(T_LOAD, S_LEFT, 1'b0, 32'h0000_0011, 32'hAABB_CCDD, 0, 1, 0, 1'b0,
                  32'h4433_2211, {32'h0BAD_0BAD, 32'h4433_2211});
    checkOutput("lwl32", lastResp32, 32'h2211_CCDD);
    checkOutput("lwl64", lastResp64, 32'h2211_CCDD);
`else
    applyStimulus(T_LOAD, S_LEFT, 1'b0, 32'h0000_0011, 32'hAABB_CCDD, 0, 1, 0, 1'b0,
                  32'h4433_2211, 64'd0);
    checkOutput("leftRejected", lastAddrErr, 1);
    checkOutput("leftNoReq", sawReq, 0);
    applyStimulus(T_STOR, S_RIGH, 1'b0, 32'h0000_0012, 32'hAABB_CCDD, 0, 0, 0, 1'b0,
                  32'd0, 64'd0);
    checkOutput("righRejected", lastAddrErr, 1);
`endif

    // Reset while in the data phase: abandoned, no response afterwards
    txnNum++;
    req_valid  = 1'b1;
    req_type   = T_LOAD;
    req_size   = S_FULL;
    req_addr   = 32'h0000_5000;
    req_signed = 1'b0;
    @(posedge clk);
    #1;
    req_valid   = 1'b0;
    bus_addr_ok = 1'b1;
    @(posedge clk);
    #1;
    bus_addr_ok = 1'b0;
    @(negedge clk);
    checkOutput("midBusReqDropped", a_bus_req, 0);
    checkOutput("midRespValid", a_resp_valid, 0);
    rst = 1'b1;
    #1;
    checkResetValues("midReset");
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus_data_ok = 1'b1;
    rdata32     = 32'h9999_9999;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("afterResetNoResp", {b_resp_valid, a_resp_valid}, 0);
      checkOutput("afterResetIdle", {b_req_ready, a_req_ready}, 2'b11);
    end
    @(posedge clk);
    #1;
    bus_data_ok = 1'b0;

    // Randomised traffic
    for (int n = 0; n < 200; n++) begin
      t = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) s = 3'($urandom_range(3, 7));
      else                          s = 3'($urandom_range(0, 2));
      applyStimulus(t, s, 1'($urandom_range(0, 1)), $urandom, $urandom,
                    $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 2),
                    1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
